// File: rtl/rv_pc_unit_if.sv
// rtl/rv_pc_unit_if.sv - decode/fetch-side signal bundle for the PC unit
interface rv_pc_unit_if #(
    parameter int XLEN = 32
);
    logic            enable;
    logic            stall;
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [3:0]      br_op;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] link_addr;
    logic            link_valid;
    logic            flush;
    logic            redirect;
    logic            trap;
    logic [XLEN-1:0] trap_pc;
    logic            halt;

    modport master (
        output enable, stall, instr, rs1, rs2, br_op,
        input  pc, link_addr, link_valid, flush, redirect, trap, trap_pc, halt
    );

    modport slave (
        input  enable, stall, instr, rs1, rs2, br_op,
        output pc, link_addr, link_valid, flush, redirect, trap, trap_pc, halt
    );
endinterface

// File: rtl/rv_pc_unit.sv
// rtl/rv_pc_unit.sv - program counter, branch resolution and redirect/flush control
module rv_pc_unit #(
    parameter int              XLEN         = 32,
    parameter bit              BYTE_ADDR    = 1'b0,
    parameter logic [XLEN-1:0] RESET_VEC    = '0,
    parameter logic [XLEN-1:0] TRAP_VEC     = 'h40,
    parameter int              FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    rv_pc_unit_if.slave  bus
);
    localparam logic [XLEN-1:0] STEP       = BYTE_ADDR ? XLEN'(4) : XLEN'(1);
    localparam logic [XLEN-1:0] CLR_BIT0   = {{(XLEN-1){1'b1}}, 1'b0};
    localparam logic [3:0]      FLUSH_INIT = 4'(FLUSH_CYCLES);

    localparam logic [3:0] OP_JAL  = 4'd1;
    localparam logic [3:0] OP_JALR = 4'd2;
    localparam logic [3:0] OP_BEQ  = 4'd3;
    localparam logic [3:0] OP_BNE  = 4'd4;
    localparam logic [3:0] OP_BLT  = 4'd5;
    localparam logic [3:0] OP_BGE  = 4'd6;
    localparam logic [3:0] OP_BLTU = 4'd7;
    localparam logic [3:0] OP_BGEU = 4'd8;

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] link_q;
    logic [XLEN-1:0] trap_pc_q;
    logic            link_valid_q;
    logic            flush_q;
    logic            redirect_q;
    logic            trap_q;

    logic [XLEN-1:0] imm_j, imm_b, imm_i, imm_sel;
    logic [XLEN-1:0] off_j, off_b;
    logic [XLEN-1:0] pc_seq, jal_tgt, br_tgt, jalr_sum, jalr_tgt, target;
    logic            is_jal, is_jalr, br_taken, taken, misaligned;
    logic            eq, lt_s, lt_u, adv;

    assign adv = bus.enable & ~bus.stall;

    // RISC-V immediate layouts, sign-extended to the datapath width
    assign imm_j = {{(XLEN-20){bus.instr[31]}}, bus.instr[19:12], bus.instr[20], bus.instr[30:21], 1'b0};
    assign imm_b = {{(XLEN-12){bus.instr[31]}}, bus.instr[7], bus.instr[30:25], bus.instr[11:8], 1'b0};
    assign imm_i = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};

    // A word-indexed PC moves in units of 4 bytes, so byte offsets are scaled down arithmetically
    assign off_j = BYTE_ADDR ? imm_j : $unsigned($signed(imm_j) >>> 2);
    assign off_b = BYTE_ADDR ? imm_b : $unsigned($signed(imm_b) >>> 2);

    assign pc_seq   = pc_q + STEP;
    assign jal_tgt  = pc_q + off_j;
    assign br_tgt   = pc_q + off_b;
    assign jalr_sum = bus.rs1 + imm_i;
    assign jalr_tgt = BYTE_ADDR ? (jalr_sum & CLR_BIT0) : ((jalr_sum & CLR_BIT0) >> 2);

    assign eq   = (bus.rs1 == bus.rs2);
    assign lt_s = ($signed(bus.rs1) < $signed(bus.rs2));
    assign lt_u = (bus.rs1 < bus.rs2);

    // Decode the branch operation; unknown encodings fall through as sequential
    always_comb begin
        is_jal   = 1'b0;
        is_jalr  = 1'b0;
        br_taken = 1'b0;
        case (bus.br_op)
            OP_JAL:  is_jal   = 1'b1;
            OP_JALR: is_jalr  = 1'b1;
            OP_BEQ:  br_taken = eq;
            OP_BNE:  br_taken = ~eq;
            OP_BLT:  br_taken = lt_s;
            OP_BGE:  br_taken = ~lt_s;
            OP_BLTU: br_taken = lt_u;
            OP_BGEU: br_taken = ~lt_u;
            default: br_taken = 1'b0;
        endcase
    end

    assign taken   = is_jal | is_jalr | br_taken;
    assign target  = is_jalr ? jalr_tgt : (is_jal ? jal_tgt : br_tgt);
    assign imm_sel = is_jal ? imm_j : imm_b;

    // Word mode cannot see low target bits, so alignment is judged on the unscaled offset or JALR sum
    assign misaligned = BYTE_ADDR ? (target[1:0] != 2'b00)
                                  : (is_jalr ? jalr_sum[1] : (imm_sel[1:0] != 2'b00));

    // RUN/FLUSH control with registered pc, pulses and flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_FLUSH;
            cnt          <= FLUSH_INIT;
            pc_q         <= RESET_VEC;
            link_q       <= '0;
            trap_pc_q    <= '0;
            link_valid_q <= 1'b0;
            flush_q      <= 1'b1;
            redirect_q   <= 1'b0;
            trap_q       <= 1'b0;
        end else begin
            link_valid_q <= 1'b0;
            redirect_q   <= 1'b0;
            trap_q       <= 1'b0;
            if (adv) begin
                if (state == ST_FLUSH) begin
                    pc_q <= pc_seq;
                    cnt  <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state   <= ST_RUN;
                        flush_q <= 1'b0;
                    end
                end else if (taken) begin
                    redirect_q <= 1'b1;
                    state      <= ST_FLUSH;
                    cnt        <= FLUSH_INIT;
                    flush_q    <= 1'b1;
                    if (is_jal || is_jalr) begin
                        link_q       <= pc_seq;
                        link_valid_q <= 1'b1;
                    end
                    if (misaligned) begin
                        pc_q      <= TRAP_VEC;
                        trap_q    <= 1'b1;
                        trap_pc_q <= pc_q;
                    end else begin
                        pc_q <= target;
                    end
                end else begin
                    pc_q <= pc_seq;
                end
            end
        end
    end

    assign bus.pc         = pc_q;
    assign bus.link_addr  = link_q;
    assign bus.link_valid = link_valid_q;
    assign bus.flush      = flush_q;
    assign bus.redirect   = redirect_q;
    assign bus.trap       = trap_q;
    assign bus.trap_pc    = trap_pc_q;
    assign bus.halt       = ~bus.enable;
endmodule

// File: tb/tb_rv_pc_unit.sv
// tb/tb_rv_pc_unit.sv - directed vector bench for rv_pc_unit
module tb_rv_pc_unit;
    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    rv_pc_unit_if #(.XLEN(32)) bb ();
    rv_pc_unit_if #(.XLEN(32)) bw ();

    rv_pc_unit #(.XLEN(32), .BYTE_ADDR(1'b1), .RESET_VEC(32'h100), .TRAP_VEC(32'h40), .FLUSH_CYCLES(2))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bb));
    rv_pc_unit #(.XLEN(32), .BYTE_ADDR(1'b0), .RESET_VEC(32'h8), .TRAP_VEC(32'h40), .FLUSH_CYCLES(2))
        dut_w (.clk(clk), .rst_n(rst_n), .bus(bw));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]  op;
        int          imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] link;
        logic [31:0] tpc;
        logic        redir;
        logic        lv;
        logic        trap;
    } vec_t;

    vec_t vt[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_j(input int imm);
        logic [31:0] v = imm;
        return {v[20], v[10:1], v[11], v[19:12], 12'h000};
    endfunction

    function automatic logic [31:0] enc_b(input int imm);
        logic [31:0] v = imm;
        return {v[12], v[10:5], 13'h0000, v[4:1], v[11], 7'h00};
    endfunction

    function automatic logic [31:0] enc_i(input int imm);
        logic [31:0] v = imm;
        return {v[11:0], 20'h00000};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic boot_b();
        bb.enable = 1'b1;
        bb.stall  = 1'b0;
        bb.br_op  = 4'd0;
        tick();
        tick();
    endtask

    initial begin
        rst_n     = 1'b1;
        bb.enable = 1'b0; bb.stall = 1'b0; bb.instr = '0; bb.rs1 = '0; bb.rs2 = '0; bb.br_op = 4'd0;
        bw.enable = 1'b0; bw.stall = 1'b0; bw.instr = '0; bw.rs1 = '0; bw.rs2 = '0; bw.br_op = 4'd0;

        // op, imm, rs1, rs2, pc, link, trap_pc, redirect, link_valid, trap; all start at pc 0x108
        vt[0]  = '{4'd0,  0,    32'h0,        32'h0,        32'h10C,      32'h0,   32'h0,   1'b0, 1'b0, 1'b0};
        vt[1]  = '{4'd12, 64,   32'h0,        32'h0,        32'h10C,      32'h0,   32'h0,   1'b0, 1'b0, 1'b0};
        vt[2]  = '{4'd1,  64,   32'h0,        32'h0,        32'h148,      32'h10C, 32'h0,   1'b1, 1'b1, 1'b0};
        vt[3]  = '{4'd1,  -8,   32'h0,        32'h0,        32'h100,      32'h10C, 32'h0,   1'b1, 1'b1, 1'b0};
        vt[4]  = '{4'd3,  16,   32'h5,        32'h5,        32'h118,      32'h0,   32'h0,   1'b1, 1'b0, 1'b0};
        vt[5]  = '{4'd4,  16,   32'h5,        32'h5,        32'h10C,      32'h0,   32'h0,   1'b0, 1'b0, 1'b0};
        vt[6]  = '{4'd5,  32,   32'hFFFFFFFF, 32'h1,        32'h128,      32'h0,   32'h0,   1'b1, 1'b0, 1'b0};
        vt[7]  = '{4'd7,  32,   32'hFFFFFFFF, 32'h1,        32'h10C,      32'h0,   32'h0,   1'b0, 1'b0, 1'b0};
        vt[8]  = '{4'd6,  8,    32'h7,        32'h7,        32'h110,      32'h0,   32'h0,   1'b1, 1'b0, 1'b0};
        vt[9]  = '{4'd8,  8,    32'h1,        32'hFFFFFFFF, 32'h10C,      32'h0,   32'h0,   1'b0, 1'b0, 1'b0};
        vt[10] = '{4'd6,  8,    32'h1,        32'hFFFFFFFF, 32'h110,      32'h0,   32'h0,   1'b1, 1'b0, 1'b0};
        vt[11] = '{4'd2,  1,    32'h301,      32'h0,        32'h40,       32'h10C, 32'h108, 1'b1, 1'b1, 1'b1};
        vt[12] = '{4'd2,  5,    32'h300,      32'h0,        32'h304,      32'h10C, 32'h0,   1'b1, 1'b1, 1'b0};
        vt[13] = '{4'd3,  6,    32'h0,        32'h0,        32'h40,       32'h0,   32'h108, 1'b1, 1'b0, 1'b1};
        vt[14] = '{4'd7,  -16,  32'h1,        32'h2,        32'hF8,       32'h0,   32'h0,   1'b1, 1'b0, 1'b0};
        vt[15] = '{4'd1,  -268, 32'h0,        32'h0,        32'hFFFFFFFC, 32'h10C, 32'h0,   1'b1, 1'b1, 1'b0};
        vt[16] = '{4'd5,  32,   32'h1,        32'hFFFFFFFF, 32'h10C,      32'h0,   32'h0,   1'b0, 1'b0, 1'b0};
        vt[17] = '{4'd4,  -4,   32'h1,        32'h2,        32'h104,      32'h0,   32'h0,   1'b1, 1'b0, 1'b0};

        // reset values, seen while rst_n is still low
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_pc",       64'(bb.pc),         64'h100);
        chk("rst_flush",    64'(bb.flush),      64'h1);
        chk("rst_redirect", 64'(bb.redirect),   64'h0);
        chk("rst_lv",       64'(bb.link_valid), 64'h0);
        chk("rst_trap",     64'(bb.trap),       64'h0);
        chk("rst_link",     64'(bb.link_addr),  64'h0);
        chk("rst_tpc",      64'(bb.trap_pc),    64'h0);
        chk("rst_halt",     64'(bb.halt),       64'h1);
        @(negedge clk);
        rst_n = 1'b1;
        bb.enable = 1'b1;
        tick();
        chk("boot1_pc",    64'(bb.pc),    64'h104);
        chk("boot1_flush", 64'(bb.flush), 64'h1);
        tick();
        chk("boot2_pc",    64'(bb.pc),    64'h108);
        chk("boot2_flush", 64'(bb.flush), 64'h0);

        // single-cycle resolution vectors, each from a fresh reset
        for (int i = 0; i < 18; i++) begin
            do_reset();
            boot_b();
            bb.br_op = vt[i].op;
            bb.rs1   = vt[i].rs1;
            bb.rs2   = vt[i].rs2;
            if (vt[i].op == 4'd2)
                bb.instr = enc_i(vt[i].imm);
            else if (vt[i].op >= 4'd3 && vt[i].op <= 4'd8)
                bb.instr = enc_b(vt[i].imm);
            else
                bb.instr = enc_j(vt[i].imm);
            tick();
            chk($sformatf("v%0d_pc", i),       64'(bb.pc),         64'(vt[i].pc));
            chk($sformatf("v%0d_redirect", i), 64'(bb.redirect),   64'(vt[i].redir));
            chk($sformatf("v%0d_lv", i),       64'(bb.link_valid), 64'(vt[i].lv));
            chk($sformatf("v%0d_link", i),     64'(bb.link_addr),  64'(vt[i].link));
            chk($sformatf("v%0d_trap", i),     64'(bb.trap),       64'(vt[i].trap));
            chk($sformatf("v%0d_tpc", i),      64'(bb.trap_pc),    64'(vt[i].tpc));
            chk($sformatf("v%0d_flush", i),    64'(bb.flush),      64'(vt[i].redir));
            bb.br_op = 4'd0;
        end

        // JAL at 0x200, then freeze the flush with enable low
        do_reset();
        boot_b();
        bb.br_op = 4'd1; bb.instr = enc_j(32'hF0);
        tick();
        chk("walk_pc", 64'(bb.pc), 64'h1F8);
        bb.br_op = 4'd0;
        tick();
        tick();
        chk("at200_pc",    64'(bb.pc),    64'h200);
        chk("at200_flush", 64'(bb.flush), 64'h0);
        bb.br_op = 4'd1; bb.instr = enc_j(32'h40);
        tick();
        chk("jal_pc",       64'(bb.pc),         64'h240);
        chk("jal_link",     64'(bb.link_addr),  64'h204);
        chk("jal_lv",       64'(bb.link_valid), 64'h1);
        chk("jal_redirect", 64'(bb.redirect),   64'h1);
        chk("jal_flush",    64'(bb.flush),      64'h1);
        bb.enable = 1'b0;
        #1;
        chk("frz_halt", 64'(bb.halt), 64'h1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("frz%0d_pc", k),       64'(bb.pc),         64'h240);
            chk($sformatf("frz%0d_flush", k),    64'(bb.flush),      64'h1);
            chk($sformatf("frz%0d_redirect", k), 64'(bb.redirect),   64'h0);
            chk($sformatf("frz%0d_lv", k),       64'(bb.link_valid), 64'h0);
        end
        bb.enable = 1'b1;
        tick();
        chk("fl1_pc",       64'(bb.pc),       64'h244);
        chk("fl1_flush",    64'(bb.flush),    64'h1);
        chk("fl1_redirect", 64'(bb.redirect), 64'h0);
        bb.br_op = 4'd0;
        tick();
        chk("fl2_pc",    64'(bb.pc),    64'h248);
        chk("fl2_flush", 64'(bb.flush), 64'h0);

        // asynchronous reset in the middle of a flush
        bb.br_op = 4'd1; bb.instr = enc_j(32'h40);
        tick();
        chk("jal2_pc",   64'(bb.pc),        64'h288);
        chk("jal2_link", 64'(bb.link_addr), 64'h24C);
        bb.br_op = 4'd0;
        tick();
        chk("mid_pc", 64'(bb.pc), 64'h28C);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_pc",    64'(bb.pc),        64'h100);
        chk("arst_flush", 64'(bb.flush),     64'h1);
        chk("arst_link",  64'(bb.link_addr), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // word-indexed unit: stall against a taken branch, then traps and JALR scaling
        bb.enable = 1'b0;
        do_reset();
        bw.enable = 1'b1;
        tick();
        tick();
        chk("w_boot_pc",    64'(bw.pc),    64'd10);
        chk("w_boot_flush", 64'(bw.flush), 64'h0);
        bw.br_op = 4'd3; bw.rs1 = 32'h3; bw.rs2 = 32'h3; bw.instr = enc_b(-8); bw.stall = 1'b1;
        tick();
        chk("w_stall_pc",       64'(bw.pc),       64'd10);
        chk("w_stall_redirect", 64'(bw.redirect), 64'h0);
        chk("w_stall_flush",    64'(bw.flush),    64'h0);
        bw.stall = 1'b0;
        tick();
        chk("w_beq_pc",       64'(bw.pc),       64'd8);
        chk("w_beq_redirect", 64'(bw.redirect), 64'h1);
        chk("w_beq_flush",    64'(bw.flush),    64'h1);
        bw.br_op = 4'd0;
        tick();
        tick();
        chk("w_run_pc", 64'(bw.pc), 64'd10);
        bw.br_op = 4'd1; bw.instr = enc_j(6);
        tick();
        chk("w_mis_pc",   64'(bw.pc),        64'h40);
        chk("w_mis_trap", 64'(bw.trap),      64'h1);
        chk("w_mis_tpc",  64'(bw.trap_pc),   64'd10);
        chk("w_mis_link", 64'(bw.link_addr), 64'd11);
        bw.br_op = 4'd0;
        tick();
        tick();
        chk("w_run2_pc", 64'(bw.pc), 64'h42);
        bw.br_op = 4'd2; bw.rs1 = 32'h40; bw.instr = enc_i(4);
        tick();
        chk("w_jalr_pc",   64'(bw.pc),        64'h11);
        chk("w_jalr_link", 64'(bw.link_addr), 64'h43);
        chk("w_jalr_trap", 64'(bw.trap),      64'h0);
        bw.br_op = 4'd0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rv_pc_unit.md
Name: rv_pc_unit

Overview:
Parametrised program-counter and branch-resolution unit for the RV32 5-stage core. It replaces the fixed word-indexed PC block. It adds configurable XLEN, addressing mode, reset and trap vectors, and a counted multi-cycle flush. It also adds correct signed and unsigned compares, misaligned-target trapping, and an explicit redirect/flush state machine. It sits between decode (instr, operands, branch op) and fetch (pc).

Parameters:
XLEN, 32, datapath and PC width (32 or 64)
BYTE_ADDR, 0, 0: word-indexed PC (step 1, offsets >>>2); 1: byte PC (step 4)
RESET_VEC, 0, PC value loaded on reset
TRAP_VEC, 'h40, PC value loaded on misaligned target
FLUSH_CYCLES, 2, cycles flush stays high after a redirect (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  global run enable; low freezes the unit
stall  in  1  downstream busy; freezes pc, state and counter
instr  in  32  instruction in decode, used for immediates
rs1  in  XLEN  source operand 1, already forwarded
rs2  in  XLEN  source operand 2, already forwarded
br_op  in  4  0 SEQ, 1 JAL, 2 JALR, 3 BEQ, 4 BNE, 5 BLT, 6 BGE, 7 BLTU, 8 BGEU; 9-15 treated as SEQ
pc  out  XLEN  current fetch PC
link_addr  out  XLEN  pc+step captured on JAL/JALR
link_valid  out  1  one-cycle pulse when link_addr is updated
flush  out  1  kill wrong-path instructions in IF/ID
redirect  out  1  one-cycle pulse when pc is loaded non-sequentially
trap  out  1  one-cycle pulse on a misaligned target
trap_pc  out  XLEN  pc of the faulting jump or branch
halt  out  1  combinational ~enable

Behaviour:
- Clock and reset: all state on posedge clk. rst_n is asynchronous active-low.
- Reset values:
  - pc=RESET_VEC, link_addr=0, trap_pc=0.
  - link_valid=0, redirect=0, trap=0.
  - flush=1, state=FLUSH, cnt=FLUSH_CYCLES.
- step = BYTE_ADDR ? 4 : 1.
- Immediates are sign-extended to XLEN:
  - immJ from instr[31],[19:12],[20],[30:21],0.
  - immB from instr[31],[7],[30:25],[11:8],0.
  - immI from instr[31:20].
- Offset applied to pc = BYTE_ADDR ? imm : imm>>>2 (arithmetic shift).
- Target computation:
  - JAL target = pc + offset(immJ).
  - JALR target = ((rs1 + immI) & ~1), then >>2 if !BYTE_ADDR.
  - Branch target = pc + offset(immB).
- Branch compares:
  - BLT/BGE use signed compare over XLEN.
  - BLTU/BGEU use unsigned compare.
  - BGE and BGEU are taken on equality.
- Misalignment:
  - BYTE_ADDR=1: a taken target with target[1:0]!=0 is misaligned.
  - BYTE_ADDR=0: a JAL/branch immediate with imm[1:0]!=0 is misaligned; so is a JALR sum with bit1 set.
- All arithmetic wraps modulo 2^XLEN. There is no overflow detection.
- State machine (RUN, FLUSH). Advance condition adv = enable & ~stall.
- RUN, with adv:
  - SEQ or not-taken branch: pc<=pc+step.
  - Taken JAL/JALR/branch, aligned: pc<=target; redirect=1; state<=FLUSH; cnt<=FLUSH_CYCLES.
  - JAL/JALR additionally set link_addr<=pc+step and link_valid=1. The link is written even if the target is misaligned.
  - Misaligned target: pc<=TRAP_VEC; trap=1; trap_pc<=pc; redirect=1; state<=FLUSH; cnt<=FLUSH_CYCLES.
- FLUSH, with adv:
  - br_op is ignored (wrong path); pc<=pc+step; cnt<=cnt-1.
  - When cnt==1, state<=RUN.
- flush = (state==FLUSH), registered.
  - flush rises the cycle after the redirect edge.
  - flush stays high for exactly FLUSH_CYCLES adv cycles.
- Stall or !enable:
  - pc, state, cnt, link_addr and trap_pc hold.
  - Pulses (redirect, link_valid, trap) are 0.
  - flush holds its value.
- Simultaneous stall and taken branch: stall wins. The branch is re-evaluated on the next adv cycle; the operands must still be valid then.
- Asynchronous reset mid-flush or mid-stall returns immediately to the reset values.

Test Plan:
- Reset, XLEN=32, BYTE_ADDR=1, RESET_VEC=0x100 -> pc=0x100 and flush=1. After 2 adv cycles flush=0 and pc=0x108.
- RUN, pc=0x200, JAL with immJ=+0x40 -> next pc=0x240, link_addr=0x204, link_valid and redirect pulse, flush high for 2 cycles, pc=0x244 and 0x248 during flush.
- BLT with rs1=0xFFFFFFFF (-1), rs2=1 -> taken. BLTU with the same operands -> not taken, pc+4. BGE with rs1==rs2 -> taken.
- BYTE_ADDR=1, JALR with rs1=0x301, immI=1 -> target 0x302, misaligned -> pc=TRAP_VEC (0x40), trap=1, trap_pc=old pc, link_addr written.
- BYTE_ADDR=0, pc=10, BEQ taken with immB=-8 -> pc=8. With stall=1 asserted that same cycle -> pc holds at 10 and no redirect. After release -> pc=8.
- enable=0 for 3 cycles during FLUSH -> halt=1; pc, cnt and flush frozen. rst_n pulsed low mid-flush -> immediate return to reset values.
